vram_wr_sched: RTL and testbench

- Write-side scheduler for the five-bank, 1-bit-wide LCD video RAM.
- Accepts single-pixel writes from the CPU/Wishbone slave.
- Contains a hardware fill engine that clears or paints a linear pixel span.
- Arbitrates both sources onto the single RAM write port. It translates each 17-bit linear pixel index into a one-hot bank write enable plus a 14-bit bank offset, driving we0..we4/addr0..addr4/dataIn of the video RAM.

---
 rtl/vram_pkg.sv | 26 ++
 rtl/vram_addr_decode.sv | 20 ++
 rtl/vram_wr_sched.sv | 163 ++++++++++++++++
 tb/tb_vram_wr_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and enums for the video RAM write scheduler.
package vram_pkg;

    localparam int BANK_DEPTH = 16384;
    localparam int NUM_BANKS  = 5;
    localparam int TOTAL_PIX  = 76800;
    localparam int PIX_W      = 17;
    localparam int OFS_W      = $clog2(BANK_DEPTH);
    localparam int BANK_W     = PIX_W - OFS_W;
    localparam int PIX_X_W    = PIX_W + 1;

    // One bit wider than a pixel index so base+len cannot wrap.
    localparam logic [PIX_X_W-1:0] PIX_LIMIT = PIX_X_W'(TOTAL_PIX);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_FILL
    } gnt_e;

endpackage

// File: rtl/vram_addr_decode.sv
// Linear pixel index to one-hot bank enable, bank offset and range flag.
module vram_addr_decode
    import vram_pkg::*;
(
    input  logic [PIX_W-1:0]     idx,
    output logic [NUM_BANKS-1:0] bank_oh,
    output logic [OFS_W-1:0]     offset,
    output logic                 illegal
);

    always_comb begin
        illegal = ({1'b0, idx} >= PIX_LIMIT);
        offset  = idx[OFS_W-1:0];
        bank_oh = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_oh[i] = !illegal && (idx[PIX_W-1:OFS_W] == BANK_W'(i));
        end
    end

endmodule

// File: rtl/vram_wr_sched.sv
// Arbitrates CPU pixel writes and the span-fill engine onto the single
// video RAM write port; all outputs are registered.
module vram_wr_sched
    import vram_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cpu_req,
    input  logic [PIX_W-1:0]     cpu_addr,
    input  logic                 cpu_data,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    input  logic                 fill_start,
    input  logic [PIX_W-1:0]     fill_base,
    input  logic [PIX_W-1:0]     fill_len,
    input  logic                 fill_value,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic [NUM_BANKS-1:0] vram_we,
    output logic [OFS_W-1:0]     vram_addr,
    output logic                 vram_din
);

    state_e               state_q, state_d;
    gnt_e                 last_q, last_d;
    logic [PIX_W-1:0]     cnt_q, cnt_d;
    logic [PIX_X_W-1:0]   end_q, end_d;
    logic                 val_q, val_d;
    logic [NUM_BANKS-1:0] we_q, we_d;
    logic [OFS_W-1:0]     addr_q, addr_d;
    logic                 din_q, din_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 cpu_elig, cpu_take, fill_take;
    logic                 cpu_ill, fill_ill;
    logic [NUM_BANKS-1:0] cpu_bank, fill_bank;
    logic [OFS_W-1:0]     cpu_ofs, fill_ofs;
    logic [PIX_X_W-1:0]   fill_sum, fill_end, cnt_nxt;

    vram_addr_decode u_cpu_dec (
        .idx     (cpu_addr),
        .bank_oh (cpu_bank),
        .offset  (cpu_ofs),
        .illegal (cpu_ill)
    );

    vram_addr_decode u_fill_dec (
        .idx     (cnt_q),
        .bank_oh (fill_bank),
        .offset  (fill_ofs),
        .illegal (fill_ill)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        end_d     = end_q;
        val_d     = val_q;
        we_d      = '0;
        addr_d    = addr_q;
        din_d     = din_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        cpu_take  = 1'b0;
        fill_take = 1'b0;

        // No re-grant while the previous ack is still on the bus.
        cpu_elig = cpu_req && !ack_q;
        fill_sum = {1'b0, fill_base} + {1'b0, fill_len};
        fill_end = (fill_sum > PIX_LIMIT) ? PIX_LIMIT : fill_sum;
        cnt_nxt  = {1'b0, cnt_q} + {{PIX_W{1'b0}}, 1'b1};

        unique case (state_q)
            IDLE: begin
                cpu_take = cpu_elig;
                if (fill_start) begin
                    cnt_d   = fill_base;
                    end_d   = fill_end;
                    val_d   = fill_value;
                    state_d = (fill_end <= {1'b0, fill_base}) ? DONE : FILL;
                end
            end
            FILL: begin
                // Illegal CPU requests need no RAM slot, so they ride along with a fill write.
                cpu_take  = cpu_elig && (cpu_ill || last_q == GNT_FILL);
                fill_take = !(cpu_take && !cpu_ill);
            end
            DONE: begin
                cpu_take = cpu_elig;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cpu_take) begin
            ack_d = 1'b1;
            err_d = cpu_ill;
            if (!cpu_ill) begin
                we_d   = cpu_bank;
                addr_d = cpu_ofs;
                din_d  = cpu_data;
                last_d = GNT_CPU;
            end
        end

        if (fill_take) begin
            we_d   = fill_bank;
            addr_d = fill_ofs;
            din_d  = val_q;
            last_d = GNT_FILL;
            cnt_d  = cnt_nxt[PIX_W-1:0];
            if (cnt_nxt >= end_q || fill_ill) begin
                state_d = DONE;
            end
        end

        busy_d = (state_d == FILL);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            last_q  <= GNT_CPU;
            cnt_q   <= '0;
            end_q   <= '0;
            val_q   <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            val_q   <= val_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_din  = din_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign fill_busy = busy_q;
    assign fill_done = done_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed bench for vram_wr_sched: CPU writes, fills, arbitration and reset.
module tb_vram_wr_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic        cpu_data = 1'b0;
    logic        cpu_ack, cpu_err;
    logic        fill_start = 1'b0;
    logic [16:0] fill_base = '0;
    logic [16:0] fill_len = '0;
    logic        fill_value = 1'b0;
    logic        fill_busy, fill_done;
    logic [4:0]  vram_we;
    logic [13:0] vram_addr;
    logic        vram_din;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    vram_wr_sched dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din)
    );

    // Outputs are registered, so sampling 1 time unit after the edge is safe.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_fill(input logic [16:0] base, input logic [16:0] len, input logic val);
        fill_base  = base;
        fill_len   = len;
        fill_value = val;
        fill_start = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        step();
        step();
        checks++;
        if ({cpu_ack, cpu_err, fill_busy, fill_done, vram_we, vram_addr, vram_din} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {cpu_ack, cpu_err, fill_busy, fill_done, vram_we, vram_addr, vram_din});
        end
        sys_rst = 1'b1;
        step();
        checks++;
        if ({vram_we, cpu_ack, fill_busy, fill_done} !== 8'd0) begin
            failures++;
            $display("FAIL reset_release got=%h want=0", {vram_we, cpu_ack, fill_busy, fill_done});
        end
    endtask

    task automatic test_cpu_write();
        cpu_req  = 1'b1;
        cpu_addr = 17'd16385;
        cpu_data = 1'b1;
        step();
        checks++;
        if ({vram_we, vram_addr, vram_din, cpu_ack, cpu_err} !== {5'b00010, 14'd1, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL cpu_write we=%b addr=%0d din=%b ack=%b err=%b want we=00010 addr=1 din=1 ack=1 err=0",
                     vram_we, vram_addr, vram_din, cpu_ack, cpu_err);
        end
        step();
        checks++;
        if ({vram_we, cpu_ack, vram_addr} !== {5'b0, 1'b0, 14'd1}) begin
            failures++;
            $display("FAIL cpu_no_regrant we=%b ack=%b addr=%0d want we=0 ack=0 addr=1",
                     vram_we, cpu_ack, vram_addr);
        end
        cpu_req = 1'b0;
        step();
        cpu_req  = 1'b1;
        cpu_addr = 17'd76799;
        cpu_data = 1'b0;
        step();
        checks++;
        if ({vram_we, vram_addr, vram_din, cpu_ack, cpu_err} !== {5'b10000, 14'd11263, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL cpu_last_pixel we=%b addr=%0d din=%b ack=%b err=%b want we=10000 addr=11263 din=0 ack=1 err=0",
                     vram_we, vram_addr, vram_din, cpu_ack, cpu_err);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_cpu_illegal();
        cpu_req  = 1'b1;
        cpu_addr = 17'd76800;
        cpu_data = 1'b1;
        step();
        checks++;
        if ({vram_we, cpu_ack, cpu_err, vram_addr, vram_din} !== {5'b0, 1'b1, 1'b1, 14'd11263, 1'b0}) begin
            failures++;
            $display("FAIL cpu_illegal we=%b ack=%b err=%b addr=%0d din=%b want we=0 ack=1 err=1 addr=11263 din=0",
                     vram_we, cpu_ack, cpu_err, vram_addr, vram_din);
        end
        cpu_req = 1'b0;
        step();
        checks++;
        if ({vram_we, cpu_ack, cpu_err} !== 7'd0) begin
            failures++;
            $display("FAIL cpu_illegal_after got=%b want=0", {vram_we, cpu_ack, cpu_err});
        end
    endtask

    task automatic test_fill_bank_cross();
        logic [4:0]  e_we;
        logic [13:0] e_addr;
        logic        e_busy, e_done;
        start_fill(17'd16382, 17'd4, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            fill_start = 1'b0;
            e_we   = 5'b0;
            e_addr = 14'd0;
            e_busy = (k <= 4);
            e_done = (k == 5);
            case (k)
                2: begin e_we = 5'b00001; e_addr = 14'd16382; end
                3: begin e_we = 5'b00001; e_addr = 14'd16383; end
                4: begin e_we = 5'b00010; e_addr = 14'd0;     end
                5: begin e_we = 5'b00010; e_addr = 14'd1;     end
                default: ;
            endcase
            checks++;
            if ({vram_we, fill_busy, fill_done} !== {e_we, e_busy, e_done}) begin
                failures++;
                $display("FAIL fill_cross_ctrl k=%0d we=%b busy=%b done=%b want we=%b busy=%b done=%b",
                         k, vram_we, fill_busy, fill_done, e_we, e_busy, e_done);
            end
            if (e_we != 5'b0) begin
                checks++;
                if ({vram_addr, vram_din} !== {e_addr, 1'b0}) begin
                    failures++;
                    $display("FAIL fill_cross_data k=%0d addr=%0d din=%b want addr=%0d din=0",
                             k, vram_addr, vram_din, e_addr);
                end
            end
        end
    endtask

    task automatic test_fill_cpu_interleave();
        int j;
        j = 0;
        cpu_req  = 1'b1;
        cpu_addr = 17'd40000;
        cpu_data = 1'b0;
        start_fill(17'd100, 17'd10, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            step();
            fill_start = 1'b0;
            checks++;
            if (k % 2 == 1) begin
                if ({vram_we, vram_addr, vram_din, cpu_ack, cpu_err} !==
                    {5'b00100, 14'(7232 + j), 1'b0, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL interleave_cpu k=%0d we=%b addr=%0d din=%b ack=%b want we=00100 addr=%0d din=0 ack=1",
                             k, vram_we, vram_addr, vram_din, cpu_ack, 7232 + j);
                end
                j++;
                cpu_addr = 17'(40000 + j);
                if (j == 11) cpu_req = 1'b0;
            end else begin
                if ({vram_we, vram_addr, vram_din, cpu_ack, cpu_err} !==
                    {5'b00001, 14'(100 + k / 2 - 1), 1'b1, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL interleave_fill k=%0d we=%b addr=%0d din=%b ack=%b want we=00001 addr=%0d din=1 ack=0",
                             k, vram_we, vram_addr, vram_din, cpu_ack, 100 + k / 2 - 1);
                end
            end
            checks++;
            if ({fill_busy, fill_done} !== {(k <= 19), (k == 20)}) begin
                failures++;
                $display("FAIL interleave_status k=%0d busy=%b done=%b want busy=%b done=%b",
                         k, fill_busy, fill_done, (k <= 19), (k == 20));
            end
        end
        step();
        checks++;
        if ({vram_we, cpu_ack, fill_busy, fill_done} !== 8'd0) begin
            failures++;
            $display("FAIL interleave_idle got=%b want=0", {vram_we, cpu_ack, fill_busy, fill_done});
        end
    endtask

    task automatic test_fill_clip();
        logic [4:0] e_we;
        start_fill(17'd76790, 17'd50, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            fill_start = 1'b0;
            e_we = (k >= 2 && k <= 11) ? 5'b10000 : 5'b00000;
            checks++;
            if ({vram_we, fill_busy, fill_done} !== {e_we, (k <= 10), (k == 11)}) begin
                failures++;
                $display("FAIL clip_ctrl k=%0d we=%b busy=%b done=%b want we=%b busy=%b done=%b",
                         k, vram_we, fill_busy, fill_done, e_we, (k <= 10), (k == 11));
            end
            if (e_we != 5'b0) begin
                checks++;
                if ({vram_addr, vram_din} !== {14'(11252 + k), 1'b1}) begin
                    failures++;
                    $display("FAIL clip_data k=%0d addr=%0d din=%b want addr=%0d din=1",
                             k, vram_addr, vram_din, 11252 + k);
                end
            end
            // A second start while busy must not disturb the running fill.
            if (k == 3) start_fill(17'd0, 17'd1, 1'b0);
        end
    endtask

    task automatic test_fill_empty();
        start_fill(17'd5, 17'd0, 1'b1);
        step();
        fill_start = 1'b0;
        checks++;
        if ({vram_we, fill_busy, fill_done} !== {5'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL len0_done we=%b busy=%b done=%b want we=0 busy=0 done=1", vram_we, fill_busy, fill_done);
        end
        step();
        checks++;
        if ({vram_we, fill_busy, fill_done} !== 7'd0) begin
            failures++;
            $display("FAIL len0_after got=%b want=0", {vram_we, fill_busy, fill_done});
        end
        start_fill(17'd80000, 17'd5, 1'b1);
        step();
        fill_start = 1'b0;
        checks++;
        if ({vram_we, fill_busy, fill_done} !== {5'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL base_oob_done we=%b busy=%b done=%b want we=0 busy=0 done=1", vram_we, fill_busy, fill_done);
        end
        step();
        checks++;
        if ({vram_we, fill_busy, fill_done} !== 7'd0) begin
            failures++;
            $display("FAIL base_oob_after got=%b want=0", {vram_we, fill_busy, fill_done});
        end
    endtask

    task automatic test_illegal_during_fill();
        start_fill(17'd200, 17'd3, 1'b0);
        step();
        fill_start = 1'b0;
        checks++;
        if ({vram_we, fill_busy} !== {5'b0, 1'b1}) begin
            failures++;
            $display("FAIL ill_fill_start we=%b busy=%b want we=0 busy=1", vram_we, fill_busy);
        end
        cpu_req  = 1'b1;
        cpu_addr = 17'd100000;
        cpu_data = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            step();
            cpu_req = 1'b0;
            checks++;
            if ({vram_we, vram_addr, vram_din, cpu_ack, cpu_err, fill_done} !==
                {5'b00001, 14'(198 + k), 1'b0, (k == 2), (k == 2), (k == 4)}) begin
                failures++;
                $display("FAIL ill_fill k=%0d we=%b addr=%0d din=%b ack=%b err=%b done=%b want addr=%0d ack=err=%b done=%b",
                         k, vram_we, vram_addr, vram_din, cpu_ack, cpu_err, fill_done, 198 + k, (k == 2), (k == 4));
            end
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        start_fill(17'd0, 17'd20, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            fill_start = 1'b0;
        end
        sys_rst = 1'b0;
        step();
        checks++;
        if ({cpu_ack, cpu_err, fill_busy, fill_done, vram_we, vram_addr, vram_din} !== 24'd0) begin
            failures++;
            $display("FAIL midfill_reset got=%h want=0",
                     {cpu_ack, cpu_err, fill_busy, fill_done, vram_we, vram_addr, vram_din});
        end
        sys_rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({vram_we, fill_busy, fill_done} !== 7'd0) begin
                failures++;
                $display("FAIL midfill_quiet k=%0d got=%b want=0", k, {vram_we, fill_busy, fill_done});
            end
        end
        start_fill(17'd3, 17'd2, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            fill_start = 1'b0;
            checks++;
            if ({vram_we, fill_busy, fill_done} !== {(k >= 2) ? 5'b00001 : 5'b00000, (k <= 2), (k == 3)}) begin
                failures++;
                $display("FAIL refill_ctrl k=%0d we=%b busy=%b done=%b", k, vram_we, fill_busy, fill_done);
            end
            if (k >= 2) begin
                checks++;
                if ({vram_addr, vram_din} !== {14'(k + 1), 1'b1}) begin
                    failures++;
                    $display("FAIL refill_data k=%0d addr=%0d din=%b want addr=%0d din=1", k, vram_addr, vram_din, k + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_illegal();
        test_fill_bank_cross();
        test_fill_cpu_interleave();
        test_fill_clip();
        test_fill_empty();
        test_illegal_during_fill();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
